fp_addsub_sequencer: RTL and testbench

//  Multi-cycle FSM controller for the shared FP add/sub mantissa datapath. Accepts one operation per handshake.

---
 rtl/fp_addsub_pkg.sv | 26 ++
 rtl/fp_addsub_sign_ctl.sv | 42 ++++
 rtl/fp_addsub_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_fp_addsub_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_addsub_pkg.sv
// Shared types and constants for the FP add/sub sequencer.
// Widths, one-hot state encoding, mantissa-compare and bypass codes.
package fp_addsub_pkg;

    localparam int EXP_W_DEF  = 8;
    localparam int MANT_W_DEF = 23;

    typedef enum logic [6:0] {
        S_IDLE  = 7'b0000001,
        S_ALIGN = 7'b0000010,
        S_ADD   = 7'b0000100,
        S_NORM  = 7'b0001000,
        S_ROUND = 7'b0010000,
        S_FIX   = 7'b0100000,
        S_DONE  = 7'b1000000
    } state_e;

    localparam logic [1:0] CMP_LT = 2'b10;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_EQ = 2'b00;

    localparam logic [1:0] BYP_NONE = 2'b00;
    localparam logic [1:0] BYP_A    = 2'b01;
    localparam logic [1:0] BYP_B    = 2'b10;

endpackage

// File: rtl/fp_addsub_sign_ctl.sv
// Effective-operation, invert-control and result-sign decode.
// Purely combinational; registered by the sequencer on acceptance.
module fp_addsub_sign_ctl
    import fp_addsub_pkg::*;
(
    input  logic       op_i,
    input  logic       sign_a_i,
    input  logic       sign_b_i,
    input  logic       zero_d_i,
    input  logic       a_exp_gt_i,
    input  logic [1:0] cmp_i,
    output logic       sb_o,
    output logic       eff_o,
    output logic       inv1_o,
    output logic       inv2_o,
    output logic       sign_o
);

    logic sb;
    logic eff;

    assign sb     = sign_b_i ^ op_i;
    assign eff    = sign_a_i ^ sb;
    assign sb_o   = sb;
    assign eff_o  = eff;
    assign inv1_o = eff & (~zero_d_i | cmp_i[1]);
    assign inv2_o = eff & zero_d_i & ~cmp_i[1];

    always_comb begin
        sign_o = sign_a_i;
        if (eff) begin
            if (zero_d_i && cmp_i == CMP_EQ) begin
                sign_o = 1'b0;
            end else if (!zero_d_i) begin
                sign_o = a_exp_gt_i ? sign_a_i : sb;
            end else begin
                sign_o = cmp_i[0] ? sign_a_i : sb;
            end
        end
    end

endmodule

// File: rtl/fp_addsub_sequencer.sv
// FSM controller stepping the shared FP add/sub mantissa datapath.
// Optional zero-operand shortcut enabled by ADDSUB_ZERO_BYPASS_EN.
module fp_addsub_sequencer
    import fp_addsub_pkg::*;
#(
    parameter int EXP_W  = EXP_W_DEF,
    parameter int MANT_W = MANT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic             sign_a,
    input  logic             sign_b,
    input  logic             a_exp_gt,
    input  logic             zero_d,
    input  logic [EXP_W-1:0] exp_diff,
    input  logic [1:0]       cmp,
    input  logic             zero_a,
    input  logic             zero_b,
    input  logic             dp_msb,
    input  logic             dp_carry,
    input  logic             dp_zero,
    input  logic             dp_exp_min,
    output logic             ld_operands,
    output logic             align_shift,
    output logic             inv1,
    output logic             inv2,
    output logic             add_en,
    output logic             norm_shl,
    output logic             norm_shr,
    output logic             round_en,
    output logic [1:0]       bypass_sel,
    output logic             result_sign,
    output logic             result_zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int SAT = MANT_W + 3;
    localparam int CW  = $clog2(SAT + 1);
    localparam int SW  = $clog2(MANT_W + 2);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [SW-1:0] shl_q;
    logic          inv1_q;
    logic          inv2_q;
    logic          pend_q;
    logic          sign_q;
    logic          zero_q;
    logic          ld_q;

    logic          sb_w;
    logic          inv1_w;
    logic          inv2_w;
    logic          sign_w;
    logic          unused_eff;
    logic          accept;
    logic          shl_go;
    logic          busy;
    logic [CW-1:0] s_w;

    fp_addsub_sign_ctl u_sign_ctl (
        .op_i       (op),
        .sign_a_i   (sign_a),
        .sign_b_i   (sign_b),
        .zero_d_i   (zero_d),
        .a_exp_gt_i (a_exp_gt),
        .cmp_i      (cmp),
        .sb_o       (sb_w),
        .eff_o      (unused_eff),
        .inv1_o     (inv1_w),
        .inv2_o     (inv2_w),
        .sign_o     (sign_w)
    );

    assign accept = in_valid & in_ready;
    assign s_w    = (exp_diff > EXP_W'(SAT)) ? CW'(SAT) : CW'(exp_diff);
    assign shl_go = ~dp_msb & (shl_q < SW'(MANT_W + 1)) & ~dp_exp_min;
    assign busy   = (state_q != S_IDLE) & (state_q != S_DONE);

    assign in_ready    = (state_q == S_IDLE) & ~rst;
    assign ld_operands = ld_q;
    assign align_shift = (state_q == S_ALIGN) & (cnt_q != '0);
    assign add_en      = state_q == S_ADD;
    assign round_en    = state_q == S_ROUND;
    assign out_valid   = state_q == S_DONE;
    assign inv1        = inv1_q & busy;
    assign inv2        = inv2_q & busy;
    assign result_sign = sign_q;
    assign result_zero = zero_q;

    // Normalize strobes follow the live datapath flags so each shift sees
    // the sum produced by the previous one.
    assign norm_shr = ((state_q == S_NORM) | (state_q == S_FIX)) & dp_carry;
    assign norm_shl = (state_q == S_NORM) & ~dp_carry & ~dp_zero & shl_go;

`ifdef ADDSUB_ZERO_BYPASS_EN
    logic [1:0] byp_q;
    assign bypass_sel = byp_q;
`else
    logic unused_zero;
    assign unused_zero = zero_a | zero_b | sb_w;
    assign bypass_sel  = BYP_NONE;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shl_q   <= '0;
            inv1_q  <= 1'b0;
            inv2_q  <= 1'b0;
            pend_q  <= 1'b0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            ld_q    <= 1'b0;
`ifdef ADDSUB_ZERO_BYPASS_EN
            byp_q   <= BYP_NONE;
`endif
        end else begin
            ld_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        inv1_q  <= inv1_w;
                        inv2_q  <= inv2_w;
                        pend_q  <= sign_w;
                        sign_q  <= 1'b0;
                        zero_q  <= 1'b0;
                        cnt_q   <= s_w;
                        shl_q   <= '0;
                        state_q <= S_ALIGN;
                        ld_q    <= 1'b1;
`ifdef ADDSUB_ZERO_BYPASS_EN
                        byp_q   <= BYP_NONE;
                        if (zero_a | zero_b) begin
                            state_q <= S_DONE;
                            ld_q    <= 1'b0;
                            byp_q   <= (zero_a & ~zero_b) ? BYP_B : BYP_A;
                            zero_q  <= zero_a & zero_b;
                            if (zero_a & zero_b) begin
                                sign_q <= sign_a & sb_w;
                            end else begin
                                sign_q <= zero_a ? sb_w : sign_a;
                            end
                        end
`endif
                    end
                end
                S_ALIGN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                    if (cnt_q <= CW'(1)) begin
                        state_q <= S_ADD;
                        sign_q  <= pend_q;
                    end
                end
                S_ADD: begin
                    state_q <= S_NORM;
                end
                S_NORM: begin
                    if (dp_carry) begin
                        state_q <= S_ROUND;
                    end else if (dp_zero) begin
                        zero_q  <= 1'b1;
                        sign_q  <= 1'b0;
                        state_q <= S_ROUND;
                    end else if (shl_go) begin
                        shl_q <= shl_q + SW'(1);
                    end else begin
                        state_q <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    state_q <= S_FIX;
                end
                S_FIX: begin
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Scoreboard bench for fp_addsub_sequencer: directed vectors, a datapath
// flag stub, and a monitor that checks timing, strobe counts and results.
module tb_fp_addsub_sequencer;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             op = 1'b0;
    logic             sign_a = 1'b0;
    logic             sign_b = 1'b0;
    logic             a_exp_gt = 1'b0;
    logic             zero_d = 1'b0;
    logic [EXP_W-1:0] exp_diff = '0;
    logic [1:0]       cmp = 2'b00;
    logic             zero_a = 1'b0;
    logic             zero_b = 1'b0;
    logic             dp_msb = 1'b1;
    logic             dp_carry = 1'b0;
    logic             dp_zero = 1'b0;
    logic             dp_exp_min = 1'b0;
    logic             ld_operands;
    logic             align_shift;
    logic             inv1;
    logic             inv2;
    logic             add_en;
    logic             norm_shl;
    logic             norm_shr;
    logic             round_en;
    logic [1:0]       bypass_sel;
    logic             result_sign;
    logic             result_zero;
    logic             out_valid;
    logic             out_ready = 1'b1;

    fp_addsub_sequencer #(.EXP_W(EXP_W), .MANT_W(MANT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .sign_a      (sign_a),
        .sign_b      (sign_b),
        .a_exp_gt    (a_exp_gt),
        .zero_d      (zero_d),
        .exp_diff    (exp_diff),
        .cmp         (cmp),
        .zero_a      (zero_a),
        .zero_b      (zero_b),
        .dp_msb      (dp_msb),
        .dp_carry    (dp_carry),
        .dp_zero     (dp_zero),
        .dp_exp_min  (dp_exp_min),
        .ld_operands (ld_operands),
        .align_shift (align_shift),
        .inv1        (inv1),
        .inv2        (inv2),
        .add_en      (add_en),
        .norm_shl    (norm_shl),
        .norm_shr    (norm_shr),
        .round_en    (round_en),
        .bypass_sel  (bypass_sel),
        .result_sign (result_sign),
        .result_zero (result_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       id;
        int       lat;
        int       nal;
        int       nshl;
        int       nshr;
        int       nadd;
        int       nrnd;
        int       nld;
        bit       i1;
        bit       i2;
        bit       sg;
        bit       zr;
        bit [1:0] bs;
    } exp_t;

    typedef struct {
        bit       op;
        bit       sa;
        bit       sb;
        bit       agt;
        bit       zd;
        int       ed;
        bit [1:0] cmp;
        bit       za;
        bit       zb;
        int       nlow;
        int       emin;
        bit       ncar;
        bit       nzer;
        bit       fcar;
        int       bp;
        exp_t     e;
    } vec_t;

    exp_t sbq[$];
    vec_t vt[$];

    int n_chk = 0;
    int n_fail = 0;
    int drv_to = 0;
    int to_seen = 0;
    bit done_flag = 1'b0;
    bit end_chk = 1'b0;

    // datapath stub: flags follow strobes observed in the previous cycle
    int st_nlow = 0;
    int st_emin = 99;
    bit st_ncar = 1'b0;
    bit st_nzer = 1'b0;
    bit st_fcar = 1'b0;
    int shl_n = 0;
    int shr_n = 0;
    bit rnd = 1'b0;

    always @(negedge clk) begin
        if (ld_operands) begin
            shl_n = 0;
            shr_n = 0;
            rnd = 1'b0;
        end
        if (norm_shl) shl_n = shl_n + 1;
        if (norm_shr) shr_n = shr_n + 1;
        if (round_en) rnd = 1'b1;
    end

    always @(posedge clk) begin
        #1;
        dp_msb     = shl_n >= st_nlow;
        dp_exp_min = shl_n >= st_emin;
        dp_zero    = st_nzer & ~rnd;
        dp_carry   = rnd ? st_fcar : (st_ncar && shr_n == 0);
    end

    function automatic void chk(string nm, int id, int act, int exp);
        n_chk = n_chk + 1;
        if (act != exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s v%0d: got %0d, expected %0d", nm, id, act, exp);
        end
    endfunction

    // monitor
    int  cyc = 0;
    int  acc = 0;
    bit  active = 1'b0;
    bit  seen = 1'b0;
    bit  prev_rst = 1'b1;
    int  m_lat, m_nal, m_nshl, m_nshr, m_nadd, m_nrnd, m_nld, m_excl;
    bit  m_i1, m_i2;
    bit [3:0] snap;

    always @(negedge clk) begin
        exp_t e;
        while (to_seen < drv_to) begin
            chk("driver_timeout", to_seen, 1, 0);
            to_seen = to_seen + 1;
        end
        if (rst) begin
            chk("reset_outputs", 0,
                int'({in_ready, ld_operands, align_shift, inv1, inv2,
                      add_en, norm_shl, norm_shr, round_en, bypass_sel,
                      result_sign, result_zero, out_valid}), 0);
            sbq.delete();
            active = 1'b0;
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) chk("in_ready_after_reset", 0, int'(in_ready), 1);
            prev_rst = 1'b0;
            cyc = cyc + 1;
            if (in_valid && in_ready) begin
                active = 1'b1;
                seen = 1'b0;
                acc = cyc;
                m_nal = 0; m_nshl = 0; m_nshr = 0;
                m_nadd = 0; m_nrnd = 0; m_nld = 0; m_excl = 0;
                m_i1 = 1'b0; m_i2 = 1'b0;
            end else if (active) begin
                m_nal  += int'(align_shift);
                m_nshl += int'(norm_shl);
                m_nshr += int'(norm_shr);
                m_nadd += int'(add_en);
                m_nrnd += int'(round_en);
                m_nld  += int'(ld_operands);
                if (!out_valid) begin
                    m_i1 |= inv1;
                    m_i2 |= inv2;
                end
                if ($countones({align_shift, add_en, norm_shl, norm_shr,
                                round_en, out_valid}) > 1)
                    m_excl = m_excl + 1;
                if (out_valid) begin
                    e = sbq.size() > 0 ? sbq[0] : '{default: 0};
                    if (!seen) begin
                        seen = 1'b1;
                        m_lat = cyc - acc;
                        snap = {result_sign, result_zero, bypass_sel};
                        chk("inv_zero_in_done", e.id, int'({inv1, inv2}), 0);
                    end else begin
                        chk("held_stable", e.id,
                            int'({result_sign, result_zero, bypass_sel}),
                            int'(snap));
                    end
                    chk("in_ready_in_done", e.id, int'(in_ready), 0);
                    if (out_ready) begin
                        if (sbq.size() == 0) begin
                            chk("unexpected_result", 0, 1, 0);
                        end else begin
                            e = sbq.pop_front();
                            chk("latency", e.id, m_lat, e.lat);
                            chk("align_shifts", e.id, m_nal, e.nal);
                            chk("norm_shl", e.id, m_nshl, e.nshl);
                            chk("norm_shr", e.id, m_nshr, e.nshr);
                            chk("add_en", e.id, m_nadd, e.nadd);
                            chk("round_en", e.id, m_nrnd, e.nrnd);
                            chk("ld_operands", e.id, m_nld, e.nld);
                            chk("inv1", e.id, int'(m_i1), int'(e.i1));
                            chk("inv2", e.id, int'(m_i2), int'(e.i2));
                            chk("result_sign", e.id, int'(snap[3]), int'(e.sg));
                            chk("result_zero", e.id, int'(snap[2]), int'(e.zr));
                            chk("bypass_sel", e.id, int'(snap[1:0]), int'(e.bs));
                            chk("strobe_overlap", e.id, m_excl, 0);
                        end
                        active = 1'b0;
                    end
                end
            end
        end
        if (done_flag && !end_chk) begin
            chk("scoreboard_empty", 0, sbq.size(), 0);
            end_chk = 1'b1;
        end
    end

    function automatic vec_t mk(int id, bit o, bit sa, bit sbb, bit agt,
                                bit zd, int ed, bit [1:0] c, bit za, bit zb,
                                int nlow, int emin, bit ncar, bit nzer,
                                bit fcar, int bp, int lat, int nal, int nshl,
                                int nshr, bit i1, bit i2, bit sg, bit zr,
                                bit [1:0] bs);
        vec_t v;
        v.op = o; v.sa = sa; v.sb = sbb; v.agt = agt; v.zd = zd;
        v.ed = ed; v.cmp = c; v.za = za; v.zb = zb;
        v.nlow = nlow; v.emin = emin; v.ncar = ncar; v.nzer = nzer;
        v.fcar = fcar; v.bp = bp;
        v.e.id = id; v.e.lat = lat; v.e.nal = nal;
        v.e.nshl = nshl; v.e.nshr = nshr;
        v.e.nadd = (bs == 2'b00) ? 1 : 0;
        v.e.nrnd = v.e.nadd;
        v.e.nld  = v.e.nadd;
        v.e.i1 = i1; v.e.i2 = i2; v.e.sg = sg; v.e.zr = zr; v.e.bs = bs;
        return v;
    endfunction

    task automatic issue(input vec_t v);
        int k;
        @(posedge clk);
        #1;
        st_nlow = v.nlow; st_emin = v.emin; st_ncar = v.ncar;
        st_nzer = v.nzer; st_fcar = v.fcar;
        out_ready = (v.bp == 0);
        op = v.op; sign_a = v.sa; sign_b = v.sb; a_exp_gt = v.agt;
        zero_d = v.zd; exp_diff = EXP_W'(v.ed); cmp = v.cmp;
        zero_a = v.za; zero_b = v.zb;
        sbq.push_back(v.e);
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) drv_to = drv_to + 1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op = ~op; sign_a = ~sign_a; exp_diff = ~exp_diff; cmp = ~cmp;
    endtask

    task automatic run(input vec_t v);
        int k;
        issue(v);
        k = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!out_valid) drv_to = drv_to + 1;
        if (v.bp > 0) begin
            repeat (v.bp) @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) drv_to = drv_to + 1;
    endtask

    initial begin
        vec_t rv;
        int k;
        vt.push_back(mk(1, 0,0,0,0,1, 0,2'b00,0,0, 0,99,1,0,0, 0, 6, 0,0,1, 0,0,0,0,2'b00));
        vt.push_back(mk(2, 1,0,0,0,1, 0,2'b00,0,0, 0,99,0,1,0, 0, 6, 0,0,0, 0,1,0,1,2'b00));
        vt.push_back(mk(3, 1,0,0,0,0, 2,2'b10,0,0, 0,99,0,0,0, 0, 7, 2,0,0, 1,0,1,0,2'b00));
        vt.push_back(mk(4, 0,1,1,1,0,40,2'b01,0,0, 0,99,0,0,1, 0,31,26,0,1, 0,0,1,0,2'b00));
        vt.push_back(mk(5, 1,0,0,0,1, 0,2'b01,0,0, 5,99,0,0,0, 0,11, 0,5,0, 0,1,0,0,2'b00));
        vt.push_back(mk(6, 1,1,1,0,1, 0,2'b01,0,0, 5, 2,0,0,0, 0, 8, 0,2,0, 0,1,1,0,2'b00));
        vt.push_back(mk(7, 0,0,1,0,1, 0,2'b10,0,0, 0,99,0,0,0, 0, 6, 0,0,0, 1,0,1,0,2'b00));
        vt.push_back(mk(8, 0,1,1,0,1, 0,2'b00,0,0, 0,99,1,0,0, 4, 6, 0,0,1, 0,0,1,0,2'b00));
        vt.push_back(mk(11,0,0,0,1,0, 1,2'b01,0,0, 0,99,0,0,0, 0, 6, 1,0,0, 0,0,0,0,2'b00));
        vt.push_back(mk(12,1,1,0,1,0,26,2'b01,0,0, 0,99,0,0,0, 0,31,26,0,0, 0,0,1,0,2'b00));
`ifdef ADDSUB_ZERO_BYPASS_EN
        vt.push_back(mk(9, 0,0,1,0,0, 3,2'b10,1,0, 0,99,0,0,0, 0, 1, 0,0,0, 0,0,1,0,2'b10));
        vt.push_back(mk(10,0,1,1,0,1, 0,2'b00,1,1, 0,99,0,1,0, 0, 1, 0,0,0, 0,0,1,1,2'b01));
`else
        vt.push_back(mk(9, 0,0,1,0,0, 3,2'b10,1,0, 0,99,0,0,0, 0, 8, 3,0,0, 1,0,1,0,2'b00));
        vt.push_back(mk(10,0,1,1,0,1, 0,2'b00,1,1, 0,99,0,1,0, 0, 6, 0,0,0, 0,0,0,1,2'b00));
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        foreach (vt[i]) run(vt[i]);

        // abort in NORM, then recover with a plain add
        rv = mk(13, 1,0,0,0,1, 0,2'b01,0,0, 5,99,0,0,0, 0, 11,0,5,0, 0,1,0,0,2'b00);
        issue(rv);
        k = 0;
        while (!norm_shl && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!norm_shl) drv_to = drv_to + 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(vt[0]);

        repeat (2) @(negedge clk);
        done_flag = 1'b1;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks",
                 n_chk);
        $fatal(1, "watchdog");
    end

endmodule
